// File: rtl/morse_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : morse_sequencer
// Brief    : Queued Morse transmitter for letters S..Z; a FIFO feeds a
//            LOAD/SEND sequencer that holds each symbol CYCLES_PER_SYMBOL
//            clocks. Define MORSE_LETTER_GAP_EN to add a 3-symbol silence
//            (GAP state) after every letter.
// Revision : 1.0 - initial release
// ============================================================================
module morse_sequencer #(
    parameter logic [31:0] CYCLES_PER_SYMBOL = 32'd25000000,
    parameter int          FIFO_DEPTH        = 4
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        letter_valid,
    input  logic [2:0]                  letter,
    output logic                        letter_ready,
    output logic                        morse_out,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] queue_count
);

    localparam int                 c_ptr_w  = $clog2(FIFO_DEPTH);
    localparam int                 c_cnt_w  = c_ptr_w + 1;
    localparam logic [c_cnt_w-1:0] c_depth  = c_cnt_w'(FIFO_DEPTH);
    localparam logic [31:0]        c_reload = CYCLES_PER_SYMBOL - 32'd1;

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_load = 2'd1;
    localparam logic [1:0] c_st_send = 2'd2;
`ifdef MORSE_LETTER_GAP_EN
    localparam logic [1:0] c_st_gap  = 2'd3;
`endif

    logic [2:0]         r_mem [FIFO_DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;
    logic [1:0]         r_state;
    logic [1:0]         w_next_state;
    logic [2:0]         r_letter;
    logic [13:0]        r_shift;
    logic [3:0]         r_remaining;
    logic [31:0]        r_sym_cnt;
    logic               w_push;
    logic               w_pop;
    logic               w_sym_end;
    logic               w_last;

    // Left-aligned patterns: after exactly L shifts the register is all zero.
    function automatic logic [13:0] f_pattern(input logic [2:0] code);
        case (code)
            3'd0:    f_pattern = 14'b10101000000000;
            3'd1:    f_pattern = 14'b11100000000000;
            3'd2:    f_pattern = 14'b10101110000000;
            3'd3:    f_pattern = 14'b10101011100000;
            3'd4:    f_pattern = 14'b10111011100000;
            3'd5:    f_pattern = 14'b11101010111000;
            3'd6:    f_pattern = 14'b11101011101110;
            default: f_pattern = 14'b11101110101000;
        endcase
    endfunction

    function automatic logic [3:0] f_length(input logic [2:0] code);
        case (code)
            3'd0:    f_length = 4'd5;
            3'd1:    f_length = 4'd3;
            3'd2:    f_length = 4'd7;
            3'd3:    f_length = 4'd9;
            3'd4:    f_length = 4'd9;
            3'd5:    f_length = 4'd11;
            3'd6:    f_length = 4'd13;
            default: f_length = 4'd11;
        endcase
    endfunction

    assign w_push    = letter_valid && letter_ready;
    assign w_pop     = (r_state == c_st_idle) && (r_count != '0);
    assign w_sym_end = (r_sym_cnt == 32'd0);
    assign w_last    = (r_remaining == 4'd1);

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= letter;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_w'(1);
                2'b01:   r_count <= r_count - c_cnt_w'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_st_idle: if (w_pop) w_next_state = c_st_load;
            c_st_load: w_next_state = c_st_send;
            c_st_send: begin
                if (w_sym_end && w_last) begin
`ifdef MORSE_LETTER_GAP_EN
                    w_next_state = c_st_gap;
`else
                    w_next_state = c_st_idle;
`endif
                end
            end
`ifdef MORSE_LETTER_GAP_EN
            c_st_gap: if (w_sym_end && w_last) w_next_state = c_st_idle;
`endif
            default: w_next_state = c_st_idle;
        endcase
    end

    always_comb begin
        letter_ready = (r_count != c_depth);
        busy         = (r_state != c_st_idle) || (r_count != '0);
        morse_out    = r_shift[13];
        queue_count  = r_count;
    end

    // The gap reuses the remaining-symbol counter to time three silent symbols.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_letter    <= 3'd0;
            r_shift     <= 14'd0;
            r_remaining <= 4'd0;
            r_sym_cnt   <= 32'd0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_pop) begin
                        r_letter <= r_mem[r_rd_ptr];
                    end
                end
                c_st_load: begin
                    r_shift     <= f_pattern(r_letter);
                    r_remaining <= f_length(r_letter);
                    r_sym_cnt   <= c_reload;
                end
                c_st_send: begin
                    if (w_sym_end) begin
                        r_shift   <= {r_shift[12:0], 1'b0};
                        r_sym_cnt <= c_reload;
`ifdef MORSE_LETTER_GAP_EN
                        r_remaining <= w_last ? 4'd3 : (r_remaining - 4'd1);
`else
                        r_remaining <= r_remaining - 4'd1;
`endif
                    end else begin
                        r_sym_cnt <= r_sym_cnt - 32'd1;
                    end
                end
`ifdef MORSE_LETTER_GAP_EN
                c_st_gap: begin
                    if (w_sym_end) begin
                        r_sym_cnt   <= c_reload;
                        r_remaining <= r_remaining - 4'd1;
                    end else begin
                        r_sym_cnt <= r_sym_cnt - 32'd1;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire
